// File: rtl/back_end_pkg.sv
// Shared definitions for the back end: FSM state encoding and the
// burst-boundary mask helper.
package back_end_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Returns (2^sizeburst)-1, clamped so it never exceeds sizecount bits.
  // With sizeburst >= sizecount the mask is all ones over the counter width,
  // and since a nonzero count never exceeds the run size, no boundary fires.
  function automatic logic [31:0] burst_mask(input int sizeburst, input int sizecount);
    int lim;
    lim = (sizeburst >= sizecount) ? sizecount : sizeburst;
    return (32'd1 << lim) - 32'd1;
  endfunction

endpackage

// File: rtl/back_end_fifo.sv
// Small synchronous first-word-fall-through FIFO: dout always shows the head
// word while empty is low. flush empties it in one cycle.
module bk_fifo
  import back_end_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int FIFOLOG2  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATAWIDTH-1:0] din,
  output logic [DATAWIDTH-1:0] dout,
  output logic                 full,
  output logic                 empty
);

  localparam int DEPTH = 1 << FIFOLOG2;

  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [FIFOLOG2-1:0]  wr_ptr;
  logic [FIFOLOG2-1:0]  rd_ptr;
  logic [FIFOLOG2:0]    count;

  // Pointers and occupancy; pointers wrap naturally at the depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because empty qualifies dout.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (FIFOLOG2+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/back_end.sv
// Output-side back end: takes datapath result words over OUT_send/OUT_rdy,
// buffers them in bk_fifo and writes them to the FSL master port. A run moves
// size words in bursts of 2^sizeburst; the FIFO drains at each burst boundary.
//
// Handshakes: a word moves from the datapath when OUT_send && OUT_rdy at a
// rising edge; OUT_rdy never depends on OUT_send. On the FSL side a word is
// written whenever FSL_M_WRITE is high at a rising edge; FSL_M_WRITE is only
// raised while FSL_M_FULL is low, and FSL_M_DATA is zero when not writing.
module back_end
  import back_end_pkg::*;
#(
  parameter int SIZECOUNT = 12,
  parameter int SIZEBURST = 8,
  parameter int DATAWIDTH = 32,
  parameter int FIFOLOG2  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clear,
  input  logic [SIZECOUNT-1:0] size,
  input  logic [SIZEBURST-1:0] sizeburst,
  input  logic                 OUT_send,
  input  logic [DATAWIDTH-1:0] OUT_data,
  output logic                 OUT_rdy,
  output logic                 FSL_M_WRITE,
  output logic [DATAWIDTH-1:0] FSL_M_DATA,
  input  logic                 FSL_M_FULL,
  output logic [SIZEBURST-1:0] OUT_count,
  output logic                 busy,
  output logic                 done,
  output state_t               dbg_state
);

  state_t               state_q;
  state_t               state_d;
  logic [SIZECOUNT-1:0] size_r;
  logic [SIZEBURST-1:0] sizeburst_r;
  logic [SIZECOUNT-1:0] acc_cnt;
  logic [SIZECOUNT-1:0] wr_cnt;
  logic [SIZECOUNT-1:0] acc_next;
  logic [SIZECOUNT-1:0] mask;
  logic                 start_ok;
  logic                 accept;
  logic                 endburst;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATAWIDTH-1:0] fifo_dout;

  assign start_ok = (state_q == IDLE) && start && !clear;
  assign accept   = OUT_send && OUT_rdy;
  assign acc_next = acc_cnt + 1'b1;
  assign mask     = SIZECOUNT'(burst_mask(int'(sizeburst_r), SIZECOUNT));
  assign endburst = (acc_next != '0) && ((acc_next & mask) == '0);

  assign OUT_rdy     = (state_q == ACCEPT) && !fifo_full && (acc_cnt < size_r);
  assign FSL_M_WRITE = (state_q != IDLE) && !fifo_empty && !FSL_M_FULL;
  assign FSL_M_DATA  = FSL_M_WRITE ? fifo_dout : '0;
  assign OUT_count   = SIZEBURST'(1) << sizeburst;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign dbg_state   = state_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; clear overrides everything, including start.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = (size == '0) ? DONE : ACCEPT;
        ACCEPT:  if (accept && (endburst || (acc_next == size_r))) state_d = DRAIN;
        DRAIN:   if (fifo_empty && !FSL_M_WRITE)
                   state_d = (wr_cnt == size_r) ? DONE : ACCEPT;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Run parameters, captured when a start is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      size_r      <= '0;
      sizeburst_r <= '0;
    end else if (start_ok) begin
      size_r      <= size;
      sizeburst_r <= sizeburst;
    end
  end

  // Accept and write counters; they cannot wrap because acc_cnt <= size_r.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_cnt <= '0;
      wr_cnt  <= '0;
    end else if (clear || start_ok) begin
      acc_cnt <= '0;
      wr_cnt  <= '0;
    end else begin
      if (accept)      acc_cnt <= acc_next;
      if (FSL_M_WRITE) wr_cnt  <= wr_cnt + 1'b1;
    end
  end

  bk_fifo #(
    .DATAWIDTH (DATAWIDTH),
    .FIFOLOG2  (FIFOLOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (clear),
    .push  (accept),
    .pop   (FSL_M_WRITE),
    .din   (OUT_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: doc/back_end.md
Name: back_end

Overview:
- Output-side counterpart of the input front end.
- Accepts result words from the datapath output port through a send/rdy handshake and buffers them in a small first-word-fall-through FIFO.
- Writes the buffered words to the FSL master interface, respecting FSL_M_FULL.
- Moves a fixed number of words per run (size), grouped into bursts of 2^sizeburst words. At each burst boundary the FIFO drains before the next burst is accepted.

Parameters:
- SIZECOUNT, 12: width of the size counters and of the size port.
- SIZEBURST, 8: width of the sizeburst and OUT_count ports.
- DATAWIDTH, 32: datapath and FSL word width.
- FIFOLOG2, 2: log2 of the FIFO depth (default depth 4).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a run; honoured only in IDLE.
- clear  in  1  synchronous abort/clear; has priority over start.
- size  in  SIZECOUNT  number of words in the run; sampled when start is accepted.
- sizeburst  in  SIZEBURST  log2 of the burst length; sampled when start is accepted.
- OUT_send  in  1  datapath output word valid.
- OUT_data  in  DATAWIDTH  datapath output word.
- OUT_rdy  out  1  back end can accept a word.
- FSL_M_WRITE  out  1  FSL master write strobe.
- FSL_M_DATA  out  DATAWIDTH  FSL master data.
- FSL_M_FULL  in  1  FSL master FIFO full.
- OUT_count  out  SIZEBURST  burst length, 1<<sizeburst truncated to SIZEBURST bits; combinational from the sizeburst port.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at the end of a run.

Behaviour:
- Reset (rst=0, asynchronous, immediate with no clock edge):
  - state=IDLE, FIFO empty, all counters zero.
  - OUT_rdy=0, FSL_M_WRITE=0, FSL_M_DATA=0, busy=0, done=0.
  - Words in flight are discarded.
- Accept handshake:
  - A word is accepted when OUT_send && OUT_rdy at a rising edge; it is pushed into the FIFO and acc_cnt increments.
  - OUT_rdy = (state==ACCEPT) && !fifo_full && (acc_cnt < size_r).
- Write side:
  - FSL_M_WRITE = (state!=IDLE) && !fifo_empty && !FSL_M_FULL.
  - FSL_M_DATA = FIFO head when FSL_M_WRITE=1, else 0.
  - Each write pops one word and increments wr_cnt.
  - Latency from accept to the earliest FSL_M_WRITE of that word is 1 cycle; there is no bypass path.
  - Words are written in acceptance order, with no loss or duplication.
- FIFO:
  - Push and pop in the same cycle are legal: occupancy is unchanged and both pointers advance.
  - A push is never issued when the FIFO is full (gated by OUT_rdy).
  - Pointers wrap modulo the FIFO depth.
- Burst boundary (endburst): the accepted word makes acc_cnt_next a nonzero multiple of 2^sizeburst_r. If sizeburst_r >= SIZECOUNT there are no burst boundaries.
- Counters are SIZECOUNT bits, zeroed on start or clear, and never wrap because acc_cnt <= size_r.
- FSM:
  - IDLE: on start (and no clear), latch size/sizeburst and zero counters. Go to DONE if size==0, else ACCEPT.
  - ACCEPT: on an accepted word with endburst, or with acc_cnt_next==size_r, go to DRAIN.
  - DRAIN: OUT_rdy=0. When the FIFO is empty and no write occurs this cycle, go to DONE if wr_cnt==size_r, else ACCEPT.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start while not in IDLE: ignored.
- clear in any state:
  - Next cycle: state=IDLE, FIFO empty, counters zero, done=0.
  - A start in the same cycle as clear is ignored.
- A stall on FSL_M_FULL never drops data. OUT_rdy falls once the FIFO is full.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, ACCEPT, DRAIN, DONE; 2-bit);
  - a burst-boundary mask function computing (2^sizeburst)-1 clamped to SIZECOUNT bits.
- One sub-module: bk_fifo.
  - Synchronous first-word-fall-through FIFO, parameterised by DATAWIDTH and FIFOLOG2.
  - Same clock and asynchronous active-low reset.
  - Ports: push, pop, din, dout, full, empty.

Test Plan:
- Nominal run: size=8, sizeburst=2, FSL_M_FULL=0, OUT_send=1 with data 1..8 → OUT_count=4; 4 accepts then OUT_rdy=0 until the FIFO is empty; FSL writes 1..8 in order; exactly one done pulse; busy falls with done.
- Backpressure: size=8, sizeburst=3, FSL_M_FULL=1 for 10 cycles after the 2nd write → FIFO fills to 4 and OUT_rdy=0; no FSL_M_WRITE while full; all 8 words arrive once, in order.
- Zero size: start with size=0 → DONE the cycle after start, done pulses once, no OUT_rdy and no FSL_M_WRITE.
- Partial burst and ignored start: size=5, sizeburst=2 → bursts of 4 then 1; done follows the 5th write; a start pulse in mid-run changes nothing.
- Clear mid-run: clear in ACCEPT with 2 words buffered → next cycle IDLE, FSL_M_WRITE=0, FIFO empty; a subsequent start with size=3 completes normally.
- Asynchronous reset: rst=0 mid-DRAIN between clock edges → OUT_rdy, FSL_M_WRITE, busy and done are 0 immediately; after release, state is IDLE.
